// File: rtl/branch_resolution_unit_pkg.sv
// Shared definitions for the branch resolution unit: branch opcode, the IF->ID
// prediction metadata record and the recovery FSM states.
package branch_resolution_unit_pkg;

    localparam logic [6:0]  BRANCH_OPC = 7'b1100011;
    localparam int unsigned META_PC_W  = 64;

    typedef struct packed {
        logic                 v;
        logic [META_PC_W-1:0] pc;
        logic                 ptaken;
        logic [META_PC_W-1:0] ptarget;
    } meta_t;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } bru_state_t;

endpackage

// File: rtl/branch_resolution_unit_sat_counter.sv
// Saturating event counter: counts up on inc and sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/branch_resolution_unit.sv
// Compares the prediction carried from IF with the branch outcome resolved in ID;
// flushes/redirects on mispredict, drives the predictor update port and counters.
module branch_resolution_unit
    import branch_resolution_unit_pkg::*;
#(
    parameter int unsigned PC_W  = 64,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             if_valid,
    input  logic [PC_W-1:0]  if_pc,
    input  logic             if_pred_taken,
    input  logic [PC_W-1:0]  if_pred_target,
    input  logic             stall,
    input  logic [6:0]       id_opcode,
    input  logic             id_taken,
    input  logic [PC_W-1:0]  id_target,
    output logic             flush,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             upd_valid,
    output logic             upd_correct,
    output logic [PC_W-1:0]  upd_pc,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);

    meta_t           meta;
    bru_state_t      state;

    logic            resolve;
    logic            is_br;
    logic            mispredict;
    logic [PC_W-1:0] meta_pc;
    logic [PC_W-1:0] meta_ptarget;
    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] fix_pc;

    always_comb begin
        meta_pc      = meta.pc[PC_W-1:0];
        meta_ptarget = meta.ptarget[PC_W-1:0];
        seq_pc       = meta_pc + PC_W'(4);
        resolve      = meta.v & ~stall & (state == RUN);
        is_br        = (id_opcode == BRANCH_OPC);
        mispredict   = 1'b0;
        fix_pc       = '0;
        if (is_br) begin
            if (meta.ptaken && !id_taken) begin
                mispredict = 1'b1;
                fix_pc     = seq_pc;
            end else if (!meta.ptaken && id_taken) begin
                mispredict = 1'b1;
                fix_pc     = id_target;
            end else if (meta.ptaken && id_taken && (meta_ptarget != id_target)) begin
                mispredict = 1'b1;
                fix_pc     = id_target;
            end
        end else if (meta.ptaken) begin
            // BTB alias hit on a non-branch: fall through to the sequential PC
            mispredict = 1'b1;
            fix_pc     = seq_pc;
        end
    end

    assign flush       = resolve & mispredict;
    assign redirect_pc = flush ? fix_pc : '0;
    assign upd_valid   = resolve & is_br;
    assign upd_correct = upd_valid & ~mispredict;
    assign upd_pc      = meta_pc;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            meta <= '0;
        end else if (!stall) begin
            meta.v       <= if_valid & ~flush;
            meta.pc      <= META_PC_W'(if_pc);
            meta.ptaken  <= if_pred_taken;
            meta.ptarget <= META_PC_W'(if_pred_target);
        end
    end

    // RECOVER masks the slot behind a redirect so it cannot resolve a second time
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (flush)  state <= RECOVER;
                RECOVER: if (!stall) state <= RUN;
                default:             state <= RUN;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_br_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (upd_valid),
        .count  (br_count)
    );

    sat_counter #(.W(CNT_W)) u_mp_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (flush & is_br),
        .count  (mp_count)
    );

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Self-checking bench for branch_resolution_unit: rule-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_branch_resolution_unit;

    localparam int unsigned PC_W  = 64;
    localparam int unsigned CNT_W = 32;
    localparam logic [6:0]  BR    = 7'b1100011;
    localparam logic [6:0]  ALU   = 7'b0010011;

    logic             clk = 1'b0;
    logic             arst_n = 1'b0;
    logic             if_valid = 1'b0;
    logic [PC_W-1:0]  if_pc = '0;
    logic             if_pred_taken = 1'b0;
    logic [PC_W-1:0]  if_pred_target = '0;
    logic             stall = 1'b0;
    logic [6:0]       id_opcode = '0;
    logic             id_taken = 1'b0;
    logic [PC_W-1:0]  id_target = '0;
    logic             flush;
    logic [PC_W-1:0]  redirect_pc;
    logic             upd_valid;
    logic             upd_correct;
    logic [PC_W-1:0]  upd_pc;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mp_count;

    int checks = 0;
    int failures = 0;

    branch_resolution_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .if_pred_target (if_pred_target),
        .stall          (stall),
        .id_opcode      (id_opcode),
        .id_taken       (id_taken),
        .id_target      (id_target),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .upd_valid      (upd_valid),
        .upd_correct    (upd_correct),
        .upd_pc         (upd_pc),
        .br_count       (br_count),
        .mp_count       (mp_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the instruction sitting in ID, whether it is the squashed
    // slot behind a redirect, and the event tallies.
    logic             m_v = 1'b0;
    logic [63:0]      m_pc = '0;
    logic             m_pt = 1'b0;
    logic [63:0]      m_ptgt = '0;
    logic             m_blocked = 1'b0;
    logic [CNT_W-1:0] m_br = '0;
    logic [CNT_W-1:0] m_mp = '0;
    logic             is_branch, wrong, live, e_flush, e_upd, e_ok;
    logic [63:0]      right_pc, e_red;

    always @(negedge clk) begin
        if (!arst_n) begin
            m_v = 1'b0; m_pc = '0; m_pt = 1'b0; m_ptgt = '0;
            m_blocked = 1'b0; m_br = '0; m_mp = '0;
            chk("rst_flush", 64'(flush), 64'd0);
            chk("rst_redirect", redirect_pc, 64'd0);
            chk("rst_upd_valid", 64'(upd_valid), 64'd0);
            chk("rst_br_count", 64'(br_count), 64'd0);
            chk("rst_mp_count", 64'(mp_count), 64'd0);
        end else begin
            is_branch = (id_opcode == BR);
            right_pc  = (is_branch && id_taken) ? id_target : m_pc + 64'd4;
            if (is_branch)
                wrong = (m_pt != id_taken) || (m_pt && id_taken && (m_ptgt != id_target));
            else
                wrong = m_pt;
            live    = m_v && !stall && !m_blocked;
            e_flush = live && wrong;
            e_red   = e_flush ? right_pc : 64'd0;
            e_upd   = live && is_branch;
            e_ok    = e_upd && !wrong;
            chk("flush", 64'(flush), 64'(e_flush));
            chk("redirect_pc", redirect_pc, e_red);
            chk("upd_valid", 64'(upd_valid), 64'(e_upd));
            chk("upd_correct", 64'(upd_correct), 64'(e_ok));
            if (e_upd) chk("upd_pc", upd_pc, m_pc);
            chk("br_count", 64'(br_count), 64'(m_br));
            chk("mp_count", 64'(mp_count), 64'(m_mp));
            if (e_upd && (m_br != '1)) m_br = m_br + 1'b1;
            if (e_flush && is_branch && (m_mp != '1)) m_mp = m_mp + 1'b1;
            if (e_flush) m_blocked = 1'b1;
            else if (!stall) m_blocked = 1'b0;
            if (!stall) begin
                m_v = if_valid && !e_flush;
                m_pc = if_pc;
                m_pt = if_pred_taken;
                m_ptgt = if_pred_target;
            end
        end
    end

    // One cycle: IF presents a prediction, ID presents the outcome of the previous slot.
    task automatic go(input logic v, input logic [63:0] pc, input logic pt, input logic [63:0] ptgt,
                      input logic st, input logic [6:0] opc, input logic tk, input logic [63:0] tgt);
        @(posedge clk);
        #1;
        if_valid = v; if_pc = pc; if_pred_taken = pt; if_pred_target = ptgt;
        stall = st; id_opcode = opc; id_taken = tk; id_target = tgt;
        @(negedge clk);
    endtask

    initial begin
        #22 arst_n = 1'b1;

        // branch 0x100 predicted not taken, resolves taken to 0x80
        go(1, 64'h100, 0, 64'h0, 0, ALU, 0, 64'h0);
        go(1, 64'h104, 0, 64'h0, 0, BR, 1, 64'h80);
        chk("t1_flush", 64'(flush), 64'd1);
        chk("t1_redirect", redirect_pc, 64'h80);
        chk("t1_upd_valid", 64'(upd_valid), 64'd1);
        chk("t1_upd_correct", 64'(upd_correct), 64'd0);
        go(1, 64'h80, 0, 64'h0, 0, BR, 1, 64'h999);
        chk("t1_no_second_flush", 64'(flush), 64'd0);
        chk("t1_mp_count", 64'(mp_count), 64'd1);
        chk("t1_br_count", 64'(br_count), 64'd1);

        // correct taken prediction, then back-to-back target mismatch
        go(1, 64'h200, 1, 64'h240, 0, ALU, 0, 64'h0);
        go(1, 64'h2f0, 1, 64'h300, 0, BR, 1, 64'h240);
        chk("t2_upd_valid", 64'(upd_valid), 64'd1);
        chk("t2_upd_correct", 64'(upd_correct), 64'd1);
        chk("t2_flush", 64'(flush), 64'd0);
        go(1, 64'h400, 1, 64'h500, 0, BR, 1, 64'h340);
        chk("t3_flush", 64'(flush), 64'd1);
        chk("t3_redirect", redirect_pc, 64'h340);
        chk("t3_upd_valid", 64'(upd_valid), 64'd1);

        // non-branch 0x400 predicted taken
        go(1, 64'h400, 1, 64'h500, 0, ALU, 0, 64'h0);
        go(1, 64'h500, 0, 64'h0, 0, ALU, 0, 64'h0);
        chk("t4_flush", 64'(flush), 64'd1);
        chk("t4_redirect", redirect_pc, 64'h404);
        chk("t4_upd_valid", 64'(upd_valid), 64'd0);
        go(1, 64'h500, 0, 64'h0, 0, ALU, 0, 64'h0);
        chk("t4_br_count", 64'(br_count), 64'd3);
        chk("t4_mp_count", 64'(mp_count), 64'd2);

        // mispredicting branch 0x500 held by stall for 3 cycles
        for (int i = 0; i < 3; i++) begin
            go(1, 64'h504, 0, 64'h0, 1, BR, 1, 64'h600);
            chk("t5_stall_flush", 64'(flush), 64'd0);
            chk("t5_stall_upd", 64'(upd_valid), 64'd0);
        end
        go(1, 64'h504, 0, 64'h0, 0, BR, 1, 64'h600);
        chk("t5_flush", 64'(flush), 64'd1);
        chk("t5_redirect", redirect_pc, 64'h600);
        chk("t5_upd_valid", 64'(upd_valid), 64'd1);

        // pc+4 wraps at the top of the address space
        go(1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 64'h10, 0, ALU, 0, 64'h0);
        chk("t5_mp_count", 64'(mp_count), 64'd3);
        chk("t5_br_count", 64'(br_count), 64'd4);
        go(0, 64'h0, 0, 64'h0, 0, ALU, 0, 64'h0);
        chk("t6_wrap_flush", 64'(flush), 64'd1);
        chk("t6_wrap_redirect", redirect_pc, 64'h0);

        // asynchronous reset during a mispredict resolution
        go(1, 64'h700, 0, 64'h0, 0, ALU, 0, 64'h0);
        go(0, 64'h0, 0, 64'h0, 0, BR, 1, 64'h800);
        chk("t7_flush", 64'(flush), 64'd1);
        chk("t7_redirect", redirect_pc, 64'h800);
        #1 arst_n = 1'b0;
        #1;
        chk("t7_async_flush", 64'(flush), 64'd0);
        chk("t7_async_redirect", redirect_pc, 64'd0);
        chk("t7_async_upd", 64'(upd_valid), 64'd0);
        chk("t7_async_br", 64'(br_count), 64'd0);
        chk("t7_async_mp", 64'(mp_count), 64'd0);
        if_valid = 1'b0; if_pc = '0; if_pred_taken = 1'b0; if_pred_target = '0;
        stall = 1'b0; id_opcode = ALU; id_taken = 1'b0; id_target = '0;
        @(negedge clk);
        #2 arst_n = 1'b1;

        // after reset: correct not-taken branch, then a redirect with stall in recovery
        go(1, 64'h900, 0, 64'h0, 0, ALU, 0, 64'h0);
        go(1, 64'hA00, 1, 64'hB00, 0, BR, 0, 64'h0);
        chk("t8_upd_correct", 64'(upd_correct), 64'd1);
        go(1, 64'hA04, 0, 64'h0, 0, ALU, 0, 64'h0);
        chk("t8_br_count", 64'(br_count), 64'd1);
        go(1, 64'hC00, 0, 64'h0, 0, BR, 1, 64'hC00);
        go(1, 64'hC00, 0, 64'h0, 1, BR, 1, 64'hC00);
        go(1, 64'hC00, 0, 64'h0, 1, BR, 1, 64'hC00);
        go(1, 64'hC04, 0, 64'h0, 0, BR, 0, 64'h0);
        go(1, 64'hC08, 0, 64'h0, 0, BR, 0, 64'h0);
        go(0, 64'h0, 0, 64'h0, 0, ALU, 0, 64'h0);
        go(0, 64'h0, 0, 64'h0, 0, ALU, 0, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
